// File: rtl/ring_shift_reg.sv
// Multi-stage rotate/shift register with parallel load and a counted run of single-stage steps.
// Define RING_SHIFT_BIDIR_EN to honour the dir input; otherwise every run moves forward.
module ring_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [WIDTH*DEPTH-1:0]   load_data,
  input  logic                     start,
  input  logic [CNT_W-1:0]         steps,
  input  logic                     dir,
  input  logic                     mode,
  input  logic [WIDTH-1:0]         ser_in,
  input  logic                     shift_en,
  output logic [WIDTH*DEPTH-1:0]   stages,
  output logic [WIDTH-1:0]         ser_out,
  output logic                     busy,
  output logic                     done,
  output logic                     dbg_state
);

  localparam int SW = WIDTH * DEPTH;

  // Handshake: start/load are single-cycle requests honoured only while busy=0;
  // done is a one-cycle completion pulse and busy=0 during it, so start may follow at once.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic             done_nxt;
  logic             accept_start;
  logic             do_step;
  logic             mode_q;
  logic             step_back;
  logic             out_back;
  logic [SW-1:0]    stg_q;
  logic [SW-1:0]    fwd_val;
  logic [SW-1:0]    step_val;

`ifdef RING_SHIFT_BIDIR_EN
  logic          dir_q;
  logic [SW-1:0] bwd_val;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
    end else if (accept_start) begin
      dir_q <= dir;
    end
  end

  assign step_back = dir_q;
  // Outside a run ser_out follows the live dir so a caller can preview the exit stage.
  assign out_back  = (state == S_RUN) ? dir_q : dir;

  always_comb begin
    bwd_val = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      bwd_val[i*WIDTH +: WIDTH] = stg_q[(i+1)*WIDTH +: WIDTH];
    end
    bwd_val[(DEPTH-1)*WIDTH +: WIDTH] = mode_q ? ser_in : stg_q[0 +: WIDTH];
  end

  assign step_val = step_back ? bwd_val : fwd_val;
`else
  logic unused_dir;

  assign unused_dir = dir;
  assign step_back  = 1'b0;
  assign out_back   = 1'b0;
  assign step_val   = fwd_val;
`endif

  always_comb begin
    fwd_val = '0;
    for (int i = 1; i < DEPTH; i++) begin
      fwd_val[i*WIDTH +: WIDTH] = stg_q[(i-1)*WIDTH +: WIDTH];
    end
    fwd_val[0 +: WIDTH] = mode_q ? ser_in : stg_q[(DEPTH-1)*WIDTH +: WIDTH];
  end

  // Controller: next state, step strobe and completion pulse.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    accept_start  = 1'b0;
    do_step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!load && start) begin
          accept_start = 1'b1;
          if (steps == '0) begin
            done_nxt = 1'b1;
          end else begin
            remaining_nxt = steps;
            state_nxt     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (shift_en) begin
          do_step       = 1'b1;
          remaining_nxt = remaining - CNT_W'(1);
          if (remaining <= CNT_W'(1)) begin
            remaining_nxt = '0;
            state_nxt     = S_IDLE;
            done_nxt      = 1'b1;
          end
        end
      end
      default: begin
        state_nxt     = S_IDLE;
        remaining_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      done      <= done_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (accept_start) begin
      mode_q <= mode;
    end
  end

  // Datapath: every stage reads its neighbour's pre-edge value through step_val.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      stg_q <= '0;
    end else if (state == S_IDLE && load) begin
      stg_q <= load_data;
    end else if (do_step) begin
      stg_q <= step_val;
    end
  end

  always_comb begin
    ser_out = out_back ? stg_q[0 +: WIDTH] : stg_q[(DEPTH-1)*WIDTH +: WIDTH];
  end

  assign stages    = stg_q;
  assign busy      = (state == S_RUN);
  assign dbg_state = (state == S_RUN);

  a_run_has_work: assert property (@(posedge clock) disable iff (!rst_n)
    (state == S_RUN) |-> (remaining != '0));
  a_done_not_busy: assert property (@(posedge clock) disable iff (!rst_n)
    !(done && busy));

endmodule

// File: doc/ring_shift_reg.md
# ring_shift_reg

Parametrised multi-stage rotate/shift register: DEPTH stages of WIDTH bits, parallel load, and a programmed run of N single-stage steps (rotate or serial shift) under a small IDLE/RUN controller. All stage updates are non-blocking, so every stage takes its neighbour's pre-edge value on the same clock edge. It is the general-purpose successor of the four-stage 1-bit rotate demo and is used as a data-rotation and delay-line primitive in task benches.

## Interface
- WIDTH, 1 — bits per stage (≥1).
- DEPTH, 4 — number of stages (≥2).
- CNT_W, 8 — width of the step counter.

- clock  in  1 — single clock, all logic on posedge.
- rst_n  in  1 — synchronous, active-low reset.
- load  in  1 — parallel load request, IDLE only.
- load_data  in  WIDTH*DEPTH — stage i = bits [i*WIDTH +: WIDTH].
- start  in  1 — begin a run, IDLE only.
- steps  in  CNT_W — number of steps, sampled with start.
- dir  in  1 — 0 forward (stage i ← i-1), 1 backward (stage i ← i+1), sampled with start.
- mode  in  1 — 0 rotate, 1 serial shift, sampled with start.
- ser_in  in  WIDTH — fill value entering the vacated end stage in shift mode, used live each step.
- shift_en  in  1 — step enable during RUN; 0 stalls.
- stages  out  WIDTH*DEPTH — current stage contents.
- ser_out  out  WIDTH — stage DEPTH-1 when forward, stage 0 when backward (live dir in IDLE, latched dir in RUN).
- busy  out  1 — high in RUN.
- done  out  1 — one-cycle pulse at run completion.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: load has priority over start; load=1 writes load_data to all stages on that edge. Otherwise start=1 latches steps, dir, mode.
  - steps=0: stay IDLE, pulse done next cycle, stages unchanged.
  - steps>0: remaining←steps, go RUN.
- RUN, shift_en=1: one step per edge, remaining decrements.
  - Forward: stage[i]←stage[i-1] for i≥1; stage[0]←stage[DEPTH-1] (rotate) or ser_in (shift).
  - Backward: stage[i]←stage[i+1] for i<DEPTH-1; stage[DEPTH-1]←stage[0] (rotate) or ser_in (shift).
- RUN, shift_en=0: no step, remaining held, still busy.
- On the edge performing the last step (remaining=1): go IDLE, done←1 on that same edge.
- load and start during RUN are ignored (not queued).
- Rotating DEPTH steps in one direction restores the original contents.

## Timing
- Reset (rst_n=0 on an edge): stages=0, busy=0, done=0, remaining=0, state IDLE; aborts a run mid-operation with no done pulse.
- Load: stages reflect load_data after the sampling edge (latency 1).
- Run with start sampled at edge k and shift_en held high: steps on edges k+1…k+N; busy high after edge k through edge k+N; done high for exactly the cycle after edge k+N, coinciding with the final stages value.
- steps=0: done high for the cycle after edge k; busy stays 0.
- Each stall cycle extends busy and delays done by one cycle.
- start asserted in the cycle done is high is accepted (state is IDLE).

## Configuration
- RING_SHIFT_BIDIR_EN defined: dir honoured as above.
- Not defined: dir input ignored, all runs forward, ser_out always stage DEPTH-1; backward logic not synthesised.

## Test plan
- Reset: load 4'b1111, then rst_n=0 for one edge → stages=0, busy=0, done=0.
- WIDTH=1, DEPTH=4: load 4'b0001, start steps=3 dir=0 mode=0 → stages 0010, 0100, 1000 on successive edges; busy 3 cycles; done one cycle with stages=1000.
- Rotate round trip: load 4'b0110, steps=4 forward → returns 0110, done once; with RING_SHIFT_BIDIR_EN, load 0001, steps=1 dir=1 → 1000.
- Shift mode: from 0000, ser_in=1, steps=2 forward → 0001 then 0011; ser_out stays 0; then ser_in=0, steps=4 → ser_out shows 0,1,1 across the last three steps before final 0000.
- Stall and abort: steps=3 with shift_en low 2 cycles mid-run → done 2 cycles later, same final data; separate run with rst_n low mid-run → zeros, no done.
- steps=0 and ignored controls: steps=0 → done next cycle, stages unchanged, busy 0; load/start during RUN have no effect.
